ghost_mode_sequencer: RTL and testbench

GHOST_MODE_SEQUENCER -- requirements
Module: ghost_mode_sequencer

---
 rtl/pacman_pkg.sv | 46 ++++
 rtl/sec_prescaler.sv | 42 ++++
 rtl/ghost_mode_sequencer.sv | 154 +++++++++++++++
 tb/tb_ghost_mode_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared state encoding, schedule table and defaults for the ghost mode sequencer
//
// Contents:
//   DEFAULT_TICKS_PER_SEC  default game tick rate
//   LAST_PHASE             final schedule phase (chase forever)
//   SEC_W / FRIGHT_W       widths of the seconds and fright counters
//   mode_state_t           IDLE / SCATTER / CHASE encoding
//   phase_secs()           duration in seconds of each schedule phase
package pacman_pkg;

  localparam int DEFAULT_TICKS_PER_SEC = 60;

  localparam int SEC_W    = 5;
  localparam int FRIGHT_W = 10;

  localparam logic [2:0] LAST_PHASE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCATTER = 2'd1,
    ST_CHASE   = 2'd2
  } mode_state_t;

  // Level schedule. Even phases scatter, odd phases chase. The last phase
  // never expires, so its entry is unused and reads as zero.
  function automatic logic [SEC_W-1:0] phase_secs(input logic [2:0] phase);
    logic [SEC_W-1:0] secs;
    case (phase)
      3'd0:    secs = 5'd7;
      3'd1:    secs = 5'd20;
      3'd2:    secs = 5'd7;
      3'd3:    secs = 5'd20;
      3'd4:    secs = 5'd5;
      3'd5:    secs = 5'd20;
      3'd6:    secs = 5'd5;
      default: secs = 5'd0;
    endcase
    return secs;
  endfunction

  // Mode a given phase index runs in.
  function automatic mode_state_t phase_mode(input logic [2:0] phase);
    return phase[0] ? ST_CHASE : ST_SCATTER;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// rtl/sec_prescaler.sv - divides enabled game ticks down to a one-second strobe
//
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-high reset
//   en         in  count this cycle (one qualified game tick)
//   clr        in  synchronous clear, dominates en
//   secStrobe  out high for the cycle whose enabled tick completes a second
module sec_prescaler
  import pacman_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic secStrobe
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + CW'(1);
    end
  end

  // Combinational so the caller can act on the same edge that wraps the count.
  assign secStrobe = en && !clr && at_last;

endmodule

// File: rtl/ghost_mode_sequencer.sv
// rtl/ghost_mode_sequencer.sv - scatter/chase level schedule with frightened overlay
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   start          in   pulse, (re)starts the schedule at phase 0
//   pause          in   level, freezes all timers and ignores tick/pelletEaten
//   tick           in   game tick strobe, the only timer advance
//   pelletEaten    in   power pellet pulse, starts or reloads fright
//   isScatter      out  ghosts head for their corners
//   isChase        out  ghosts chase their targets
//   isFrightened   out  frightened overlay active
//   frightFlash    out  fright about to end
//   reverseGhosts  out  one-cycle pulse, all ghosts turn around
//   phase          out  current schedule phase 0..7
module ghost_mode_sequencer
  import pacman_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
  parameter int FRIGHT_SECS   = 6,
  parameter int FLASH_SECS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       tick,
  input  logic       pelletEaten,
  output logic       isScatter,
  output logic       isChase,
  output logic       isFrightened,
  output logic       frightFlash,
  output logic       reverseGhosts,
  output logic [2:0] phase
);

  localparam int FRIGHT_TICKS = FRIGHT_SECS * TICKS_PER_SEC;
  localparam int FLASH_TICKS  = FLASH_SECS * TICKS_PER_SEC;
  localparam logic [FRIGHT_W-1:0] FRIGHT_LOAD  = FRIGHT_W'(FRIGHT_TICKS);
  localparam logic [FRIGHT_W-1:0] FLASH_THRESH = FRIGHT_W'(FLASH_TICKS);
  localparam bit FRIGHT_ON = (FRIGHT_SECS > 0);

  mode_state_t         state_q, state_d;
  logic [2:0]          phase_d;
  logic [SEC_W-1:0]    sec_q, sec_d, sec_inc;
  logic [FRIGHT_W-1:0] fright_cnt_q, fright_cnt_d;
  logic                fright_q, fright_d;
  logic                rev_d;

  logic scatter_d, chase_d, flash_d;
  logic tick_ok, pellet_ok, presc_en, sec_strobe;

  // Events only count once a level is running and the game is not paused.
  assign tick_ok   = tick && !pause && (state_q != ST_IDLE);
  assign pellet_ok = FRIGHT_ON && pelletEaten && !pause && (state_q != ST_IDLE);

  // The mode timer only sees ticks outside fright. A pellet on the same
  // tick as a phase expiry wins, so that tick is withheld from the prescaler
  // and the expiry is replayed by the first tick after fright ends.
  assign presc_en = tick_ok && !fright_q && !pellet_ok && !start;

  sec_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_prescaler (
    .clk       (clk),
    .reset     (reset),
    .en        (presc_en),
    .clr       (start),
    .secStrobe (sec_strobe)
  );

  assign sec_inc = sec_q + SEC_W'(1);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase         <= 3'd0;
      sec_q         <= '0;
      fright_cnt_q  <= '0;
      fright_q      <= 1'b0;
      isScatter     <= 1'b0;
      isChase       <= 1'b0;
      isFrightened  <= 1'b0;
      frightFlash   <= 1'b0;
      reverseGhosts <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase         <= phase_d;
      sec_q         <= sec_d;
      fright_cnt_q  <= fright_cnt_d;
      fright_q      <= fright_d;
      isScatter     <= scatter_d;
      isChase       <= chase_d;
      isFrightened  <= fright_d;
      frightFlash   <= flash_d;
      reverseGhosts <= rev_d;
    end
  end

  // Next-state logic. Priority: start, pellet, fright countdown, mode timer.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase;
    sec_d        = sec_q;
    fright_cnt_d = fright_cnt_q;
    fright_d     = fright_q;
    rev_d        = 1'b0;

    if (start) begin
      state_d      = ST_SCATTER;
      phase_d      = 3'd0;
      sec_d        = '0;
      fright_cnt_d = '0;
      fright_d     = 1'b0;
    end else if (pellet_ok) begin
      // Also covers a reload on the very tick the old fright would expire.
      fright_d     = 1'b1;
      fright_cnt_d = FRIGHT_LOAD;
      rev_d        = 1'b1;
    end else if (tick_ok && fright_q) begin
      if (fright_cnt_q <= FRIGHT_W'(1)) begin
        // Fright over; the saved phase carries on with its remaining time.
        fright_cnt_d = '0;
        fright_d     = 1'b0;
      end else begin
        fright_cnt_d = fright_cnt_q - FRIGHT_W'(1);
      end
    end else if (sec_strobe && (phase != LAST_PHASE)) begin
      if (sec_inc == phase_secs(phase)) begin
        phase_d = phase + 3'd1;
        state_d = phase_mode(phase + 3'd1);
        sec_d   = '0;
        rev_d   = 1'b1;
      end else begin
        sec_d = sec_inc;
      end
    end
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    scatter_d = 1'b0;
    chase_d   = 1'b0;
    flash_d   = 1'b0;
    if (fright_d) begin
      flash_d = (fright_cnt_d <= FLASH_THRESH);
    end else begin
      scatter_d = (state_d == ST_SCATTER);
      chase_d   = (state_d == ST_CHASE);
    end
  end

endmodule

// File: tb/tb_ghost_mode_sequencer.sv
// tb/tb_ghost_mode_sequencer.sv - directed bench for ghost_mode_sequencer
module tb_ghost_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       tick = 1'b0;
  logic       pelletEaten = 1'b0;
  logic       isScatter, isChase, isFrightened, frightFlash, reverseGhosts;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] last_outs;

  always #5 clk = ~clk;

  ghost_mode_sequencer #(
    .TICKS_PER_SEC(4),
    .FRIGHT_SECS  (6),
    .FLASH_SECS   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pause        (pause),
    .tick         (tick),
    .pelletEaten  (pelletEaten),
    .isScatter    (isScatter),
    .isChase      (isChase),
    .isFrightened (isFrightened),
    .frightFlash  (frightFlash),
    .reverseGhosts(reverseGhosts),
    .phase        (phase)
  );

  // {isScatter, isChase, isFrightened, frightFlash, reverseGhosts, phase[2:0]}
  function automatic logic [7:0] outs();
    return {isScatter, isChase, isFrightened, frightFlash, reverseGhosts, phase};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One qualified tick followed by an idle cycle; last_outs holds the
  // outputs right after the tick edge.
  task automatic do_tick();
    tick = 1'b1;
    step();
    last_outs = outs();
    tick = 1'b0;
    pelletEaten = 1'b0;
    step();
  endtask

  task automatic reset_and_start();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       pause;
    logic       tick;
    logic       pellet;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    int bad;
    int revs;
    int durs[7];
    logic [7:0] exp;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "idle_pellet_ignored"};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "idle_tick_ignored"};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h80, "start_beats_pellet"};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h80, "paused_pellet_ignored"};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h80, "scatter_tick"};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h28, "pellet_fright_reverse"};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h20, "fright_reverse_one_cycle"};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h28, "pellet_reload_reverse"};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h80, "start_clears_fright"};

    // Reset state
    step();
    check("reset_outputs", 32'(outs()), 32'h00);
    reset = 1'b0;
    step();
    check("idle_after_release", 32'(outs()), 32'h00);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 9; i++) begin
      start       = vecs[i].start;
      pause       = vecs[i].pause;
      tick        = vecs[i].tick;
      pelletEaten = vecs[i].pellet;
      step();
      start = 1'b0; pause = 1'b0; tick = 1'b0; pelletEaten = 1'b0;
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
    end

    // Phase 0 lasts exactly 28 ticks
    reset_and_start();
    check("start_scatter", 32'(outs()), 32'h80);
    bad = 0;
    for (int k = 1; k <= 27; k++) begin
      do_tick();
      if (last_outs !== 8'h80) bad++;
    end
    check("phase0_hold_27", 32'(bad), 32'd0);
    do_tick();
    check("phase0_expire_edge", 32'(last_outs), 32'h49);
    check("phase1_reverse_gone", 32'(outs()), 32'h41);

    // Remaining schedule up to phase 7
    durs = '{0, 80, 28, 80, 20, 80, 20};
    for (int p = 1; p <= 6; p++) begin
      bad = 0;
      for (int k = 1; k < durs[p]; k++) begin
        do_tick();
        if (last_outs[3] !== 1'b0 || last_outs[2:0] !== 3'(p)) bad++;
      end
      check($sformatf("phase%0d_hold", p), 32'(bad), 32'd0);
      do_tick();
      exp = {~1'(p + 1), 1'(p + 1), 1'b0, 1'b0, 1'b1, 3'(p + 1)};
      check($sformatf("phase%0d_expire", p), 32'(last_outs), 32'(exp));
    end
    revs = 0;
    bad  = 0;
    for (int k = 0; k < 1000; k++) begin
      do_tick();
      if (last_outs[3] === 1'b1) revs++;
      if (last_outs !== 8'h47) bad++;
    end
    check("phase7_no_reverse", 32'(revs), 32'd0);
    check("phase7_stable", 32'(bad), 32'd0);
    check("phase7_final", 32'(outs()), 32'h47);

    // Fright mid phase 0, remaining time preserved
    reset_and_start();
    for (int k = 0; k < 10; k++) do_tick();
    pelletEaten = 1'b1;
    step();
    pelletEaten = 1'b0;
    check("fright_enter", 32'(outs()), 32'h28);
    bad = 0;
    for (int k = 1; k <= 24; k++) begin
      do_tick();
      exp = (k < 24) ? {1'b0, 1'b0, 1'b1, (24 - k <= 8), 1'b0, 3'd0} : 8'h80;
      if (last_outs !== exp) begin
        bad++;
        $display("FAIL fright_tick_%0d: got %0h expected %0h", k, last_outs, exp);
      end
    end
    check("fright_countdown", 32'(bad), 32'd0);
    bad = 0;
    for (int k = 0; k < 17; k++) begin
      do_tick();
      if (last_outs !== 8'h80) bad++;
    end
    check("resume_remaining_17", 32'(bad), 32'd0);
    do_tick();
    check("resume_expire_at_18", 32'(last_outs), 32'h49);

    // Pellet on the expiring tick of phase 0
    reset_and_start();
    for (int k = 0; k < 27; k++) do_tick();
    pelletEaten = 1'b1;
    do_tick();
    check("pellet_beats_expiry", 32'(last_outs), 32'h28);
    for (int k = 0; k < 24; k++) do_tick();
    check("fright_end_no_reverse", 32'(last_outs), 32'h80);
    do_tick();
    check("deferred_expiry", 32'(last_outs), 32'h49);

    // Pause freezes everything, then reset mid-fright
    reset_and_start();
    for (int k = 0; k < 5; k++) do_tick();
    pelletEaten = 1'b1;
    step();
    pelletEaten = 1'b0;
    step();
    check("pause_setup", 32'(outs()), 32'h20);
    pause = 1'b1;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick        = (c % 2 == 0);
      pelletEaten = (c == 20);
      step();
      if (outs() !== 8'h20) bad++;
    end
    pause = 1'b0; tick = 1'b0; pelletEaten = 1'b0;
    check("pause_frozen", 32'(bad), 32'd0);
    for (int k = 0; k < 15; k++) do_tick();
    check("pause_held_fright_cnt", 32'(last_outs), 32'h20);
    do_tick();
    check("flash_after_16", 32'(last_outs), 32'h30);
    do_tick();
    do_tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset_mid_fright", 32'(outs()), 32'h00);
    step();
    reset = 1'b0;
    step();
    check("reset_release_no_reverse", 32'(outs()), 32'h00);
    pelletEaten = 1'b1;
    do_tick();
    do_tick();
    check("idle_after_reset_ticks", 32'(last_outs), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
